// File: rtl/dct4_fwd_serial.sv
// dct4_fwd_serial
//   Forward 4-point integer DCT using the HEVC core matrix (64, 83, 36).
//   One block of four signed samples is accepted per handshake. The four
//   coefficients are computed at full precision with an even/odd butterfly,
//   then streamed out one per beat in index order 0..3.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   sample block present on x0..x3
//   in_ready   block can be accepted this cycle (IDLE only)
//   x0..x3     signed input samples, IN_W bits
//   out_valid  out_coef / out_idx / out_last are valid
//   out_ready  downstream accepts the current coefficient
//   out_coef   signed coefficient, OUT_W bits
//   out_idx    coefficient index 0..3
//   out_last   high together with index 3
module dct4_fwd_serial #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  x0,
    input  logic signed [IN_W-1:0]  x1,
    input  logic signed [IN_W-1:0]  x2,
    input  logic signed [IN_W-1:0]  x3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_coef,
    output logic [1:0]              out_idx,
    output logic                    out_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic [1:0] idx_reg, idx_next;

    logic signed [IN_W-1:0]  x_in  [4];
    logic signed [IN_W-1:0]  x_reg [4];
    logic signed [OUT_W-1:0] xs    [4];
    logic signed [OUT_W-1:0] c_calc [4];
    logic signed [OUT_W-1:0] c_reg  [4];

    logic signed [OUT_W-1:0] e0, e1, o0, o1;

    // Constant multiplies as shift-add: 83 = 64+16+2+1, 36 = 32+4.
    function automatic logic signed [OUT_W-1:0] mul83(input logic signed [OUT_W-1:0] v);
        return (v <<< 6) + (v <<< 4) + (v <<< 1) + v;
    endfunction

    function automatic logic signed [OUT_W-1:0] mul36(input logic signed [OUT_W-1:0] v);
        return (v <<< 5) + (v <<< 2);
    endfunction

    assign x_in[0] = x0;
    assign x_in[1] = x1;
    assign x_in[2] = x2;
    assign x_in[3] = x3;

    // Sign-extend each latched sample to the coefficient width up front so
    // every add and multiply below happens in the OUT_W domain and cannot wrap.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ext
            assign xs[gi] = {{(OUT_W-IN_W){x_reg[gi][IN_W-1]}}, x_reg[gi]};
        end
    endgenerate

    // Even/odd butterfly followed by the matrix rows.
    assign e0 = xs[0] + xs[3];
    assign e1 = xs[1] + xs[2];
    assign o0 = xs[0] - xs[3];
    assign o1 = xs[1] - xs[2];

    assign c_calc[0] = (e0 + e1) <<< 6;
    assign c_calc[2] = (e0 - e1) <<< 6;
    assign c_calc[1] = mul83(o0) + mul36(o1);
    assign c_calc[3] = mul36(o0) - mul83(o1);

    // State, index, sample and coefficient registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                x_reg[i] <= '0;
                c_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (state_reg == IDLE && in_valid) begin
                for (int i = 0; i < 4; i++) begin
                    x_reg[i] <= x_in[i];
                end
            end
            if (state_reg == CALC) begin
                for (int i = 0; i < 4; i++) begin
                    c_reg[i] <= c_calc[i];
                end
            end
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                idx_next   = 2'd0;
                state_next = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_reg == 2'd3) begin
                        idx_next   = 2'd0;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 2'd0;
            end
        endcase
    end

    // Outputs come straight from registers, so they stay stable under
    // backpressure. The coefficient is forced to zero outside SEND so the
    // bus is quiet when nothing is being offered.
    assign out_coef = out_valid ? c_reg[idx_reg] : '0;
    assign out_idx  = idx_reg;
    assign out_last = out_valid && (idx_reg == 2'd3);

endmodule

// File: doc/dct4_fwd_serial.md
Name: dct4_fwd_serial

Overview:
- Forward 4-point integer DCT (HEVC core matrix: 64, 83, 36) that produces the coefficient stream consumed by the 4-point IDCT datapath.
- Accepts one block of four signed residual samples per valid/ready handshake.
- Computes all four coefficients with an even/odd butterfly, then emits them serially, index 0..3, on a valid/ready output with backpressure.
- Full precision; no rounding or shift. Output width matches the IDCT's 24-bit accumulator domain.

Parameters:
- IN_W, 16, signed sample width.
- OUT_W, 24, signed coefficient width; must be ≥ IN_W+8.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  sample block present on x0..x3.
- in_ready  output  1  block can be accepted this cycle.
- x0  input  IN_W  sample 0, signed.
- x1  input  IN_W  sample 1, signed.
- x2  input  IN_W  sample 2, signed.
- x3  input  IN_W  sample 3, signed.
- out_valid  output  1  out_coef/out_idx valid.
- out_ready  input  1  downstream accepts the current coefficient.
- out_coef  output  OUT_W  coefficient, signed.
- out_idx  output  2  coefficient index 0..3.
- out_last  output  1  high with idx 3.

Behaviour:
- Reset (synchronous, active-high, checked at the clock edge): state=IDLE, idx=0, out_valid=0, out_coef=0, out_idx=0, out_last=0. Sample and coefficient registers are cleared to 0. in_ready=1 in the cycle after reset is released.
- **IDLE:**
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready at an edge: latch x0..x3 and go to CALC.
- **CALC (exactly 1 cycle):**
  - in_ready=0.
  - Butterfly: e0=x0+x3, e1=x1+x2, o0=x0-x3, o1=x1-x2 (IN_W+1 bits, sign-extended).
  - Coefficients:
    - c0=64*(e0+e1)
    - c2=64*(e0-e1)
    - c1=83*o0+36*o1
    - c3=36*o0-83*o1
  - All arithmetic is signed, sign-extended to OUT_W before multiplying. Constant multiplies use shift-add.
  - Register c0..c3, set idx=0, go to SEND.
- **SEND:**
  - in_ready=0, out_valid=1.
  - out_coef=c[idx], out_idx=idx, out_last=(idx==3).
  - On out_valid & out_ready:
    - idx<3: idx increments.
    - idx==3: go to IDLE, out_valid drops next cycle.
  - out_ready low: all outputs hold stable. No change is permitted while valid is high and not accepted.
- Latency: accept edge T → out_valid high in the cycle after edge T+1 → idx0 is visible two cycles after acceptance.
- Throughput: minimum 6 cycles per block (1 accept, 1 calc, 4 send).
- in_valid while in_ready=0 is ignored. Upstream must hold its data; the block does not sample it.
- Width rule: the worst case |c1|=119*(2^IN_W - 1) fits OUT_W=24 for IN_W=16. Results are never saturated and never wrap for legal parameters.
- Reset in CALC or SEND: the block is discarded immediately, no partial output, state returns to IDLE.
- out_ready held high continuously: four consecutive beats, idx 0,1,2,3.

Test Plan:
- x=(1,0,0,0), out_ready=1 → beats 64, 83, 64, 36 with idx 0..3; out_last only on beat 3; out_valid rises 2 cycles after accept.
- x=(0,1,0,0) → 64, 36, -64, -83; x=(1,1,1,1) → 256, 0, 0, 0.
- Extremes x=(32767,32767,-32768,-32768) → c0=-128, c1=7798665, c2=0, c3=-3080145; no overflow.
- Backpressure: out_ready low for 3 cycles at idx1 → out_coef/out_idx held constant; resumes with idx2 after out_ready rises; in_ready stays 0 throughout.
- Back-to-back blocks with in_valid always high → second block accepted only in the IDLE cycle after the idx3 handshake; 6-cycle period observed.
- Reset asserted during SEND at idx2 → next cycle out_valid=0, in_ready=1; the following block emits from idx0 with correct values.
